// File: rtl/ms_slave_feeder.sv
// ms_slave_feeder: upstream producer for the master/slave test-case modules.
// It accepts one message from the master port, adds a signed OFFSET, and
// presents the result to the slave with a single-cycle sync strobe. A quiet
// gap of GAP_CYCLES cycles follows each strobe. xfer_cnt counts completed
// strobes.
// Optional build macro MS_SLAVE_FEEDER_SAT_EN: the add saturates to the
// 32-bit signed range instead of wrapping.
//
// Handshake: a message transfers on a rising clk edge where m_in_valid and
// m_in_ready are both high. m_in_ready is combinational and is high only in
// IDLE with en set and rst low. m_in_valid may drop without a transfer.
// When there is no transfer, the feeder latches nothing.
module ms_slave_feeder #(
  parameter logic signed [31:0] OFFSET     = 32'sd0,
  parameter int unsigned        GAP_CYCLES = 2,
  parameter int unsigned        CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [31:0]      m_in_msg,
  input  logic                    m_in_valid,
  output logic                    m_in_ready,
  output logic signed [31:0]      s_out,
  output logic                    s_out_sync,
  output logic                    busy,
  output logic [CNT_W-1:0]        xfer_cnt,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } state_t;

  // The gap counter holds at most GAP_CYCLES-1.
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  state_t              state_q;
  state_t              state_d;
  logic [GW-1:0]       gap_q;
  logic                hs;
  logic signed [31:0]  result;

  assign m_in_ready = (state_q == IDLE) && en && !rst;
  assign hs         = m_in_valid && m_in_ready;
  assign busy       = (state_q != IDLE);
  assign state_dbg  = state_q;

`ifdef MS_SLAVE_FEEDER_SAT_EN
  logic signed [32:0] sum_wide;

  // Widened add keeps the true sign, so overflow is visible and can be clamped.
  always_comb begin
    sum_wide = {m_in_msg[31], m_in_msg} + {OFFSET[31], OFFSET};
    if (sum_wide[32] != sum_wide[31]) begin
      result = sum_wide[32] ? 32'sh8000_0000 : 32'sh7fff_ffff;
    end else begin
      result = sum_wide[31:0];
    end
  end
`else
  // Plain two's-complement add; overflow wraps.
  assign result = m_in_msg + OFFSET;
`endif

  // Next-section logic: EMIT always lasts one cycle, and GAP ends when the gap counter runs out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = EMIT;
      EMIT:    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (gap_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Section register. Reset aborts any transfer immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: latch on handshake, register the strobe, count strobes, and time the gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_out      <= '0;
      s_out_sync <= 1'b0;
      xfer_cnt   <= '0;
      gap_q      <= '0;
    end else begin
      s_out_sync <= hs;
      if (hs) begin
        s_out <= result;
      end
      if (state_q == EMIT) begin
        xfer_cnt <= xfer_cnt + 1'b1;
        gap_q    <= GAP_LOAD;
      end else if ((state_q == GAP) && (gap_q != '0)) begin
        gap_q <= gap_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ms_slave_feeder.sv
// Testbench for ms_slave_feeder. Four instances with different OFFSET,
// GAP_CYCLES and CNT_W share one clock. A transaction-level reference model
// predicts every output every cycle: the handshake time, the strobe cycle,
// the latched value, when the feeder is free again, and the count.
module tb_ms_slave_feeder;

  localparam int N = 4;
  localparam int OFFS [N] = '{0, 0, 1, -1};
  localparam int GAPS [N] = '{2, 0, 1, 3};
  localparam int CNTS [N] = '{16, 2, 16, 4};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic        en_v    [N];
  logic        valid_v [N];
  logic        ready_v [N];
  logic        sync_v  [N];
  logic        busy_v  [N];
  logic [31:0] msg_v   [N];
  logic [31:0] sout_v  [N];
  logic [15:0] cnt_v   [N];
  logic [1:0]  st_v    [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int CW = CNTS[g];
    logic [CW-1:0] cnt_w;
    ms_slave_feeder #(
      .OFFSET(OFFS[g]),
      .GAP_CYCLES(GAPS[g]),
      .CNT_W(CW)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .en(en_v[g]),
      .m_in_msg(msg_v[g]),
      .m_in_valid(valid_v[g]),
      .m_in_ready(ready_v[g]),
      .s_out(sout_v[g]),
      .s_out_sync(sync_v[g]),
      .busy(busy_v[g]),
      .xfer_cnt(cnt_w),
      .state_dbg(st_v[g])
    );
    assign cnt_v[g] = 16'(cnt_w);
  end

  // stimulus drive values and reference model state
  logic        e_d [N];
  logic        v_d [N];
  logic [31:0] m_d [N];
  logic        hs_last [N];
  int          cyc;
  int          free_at  [N];
  int          sync_at  [N];
  logic [31:0] exp_sout [N];
  int          exp_cnt  [N];
  logic [33:0] exp_q[$];
  int          checks;
  int          failures;

  function automatic logic [31:0] model_add(logic [31:0] m, int off);
    longint s;
    s = longint'($signed(m)) + longint'(off);
`ifdef MS_SLAVE_FEEDER_SAT_EN
    if (s > 64'sd2147483647) return 32'h7fff_ffff;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return s[31:0];
  endfunction

  function automatic logic [31:0] pick_msg();
    logic [31:0] edge_tab [6];
    edge_tab = '{32'h7fff_ffff, 32'h8000_0000, 32'hffff_ffff, 32'h0, 32'h7fff_fffe, 32'h8000_0001};
    if ($urandom_range(0, 2) == 0) return edge_tab[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  // Driver plus scoreboard: one clock cycle for all instances.
  task automatic tick();
    logic hs [N];
    logic exp_rdy;
    int   k;
    for (int i = 0; i < N; i++) begin
      en_v[i]    = e_d[i];
      valid_v[i] = v_d[i];
      msg_v[i]   = m_d[i];
    end
    #1;
    for (int i = 0; i < N; i++) begin
      exp_rdy = !rst && e_d[i] && (cyc >= free_at[i]);
      checks++;
      if (ready_v[i] !== exp_rdy) begin
        failures++;
        $display("FAIL ready[%0d] cyc=%0d got=%b exp=%b", i, cyc, ready_v[i], exp_rdy);
      end
      hs[i]      = v_d[i] && exp_rdy;
      hs_last[i] = hs[i];
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        exp_q.push_back({2'(i), model_add(m_d[i], OFFS[i])});
        sync_at[i] = cyc;
        free_at[i] = cyc + 1 + GAPS[i];
      end
      if (sync_at[i] == cyc) begin
        k = -1;
        for (int j = 0; j < exp_q.size(); j++) begin
          if (k < 0 && exp_q[j][33:32] == 2'(i)) k = j;
        end
        if (k >= 0) begin
          exp_sout[i] = exp_q[k][31:0];
          exp_q.delete(k);
        end
      end
      checks++;
      if (sync_v[i] !== (sync_at[i] == cyc)) begin
        failures++;
        $display("FAIL sync[%0d] cyc=%0d got=%b exp=%b", i, cyc, sync_v[i], (sync_at[i] == cyc));
      end
      checks++;
      if (sout_v[i] !== exp_sout[i]) begin
        failures++;
        $display("FAIL s_out[%0d] cyc=%0d got=%h exp=%h", i, cyc, sout_v[i], exp_sout[i]);
      end
      checks++;
      if (busy_v[i] !== (cyc < free_at[i])) begin
        failures++;
        $display("FAIL busy[%0d] cyc=%0d got=%b exp=%b", i, cyc, busy_v[i], (cyc < free_at[i]));
      end
      checks++;
      if (cnt_v[i] !== 16'(exp_cnt[i])) begin
        failures++;
        $display("FAIL xfer_cnt[%0d] cyc=%0d got=%0d exp=%0d", i, cyc, cnt_v[i], exp_cnt[i]);
      end
      if (sync_at[i] == cyc) exp_cnt[i] = (exp_cnt[i] + 1) % (1 << CNTS[i]);
    end
  endtask

  // Asynchronous reset, checked immediately, then held for two edges.
  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      v_d[i] = 1'b0;
      e_d[i] = 1'b1;
      m_d[i] = 32'h0;
      en_v[i] = 1'b1;
      valid_v[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (sync_v[i] !== 1'b0 || sout_v[i] !== 32'h0 || cnt_v[i] !== 16'h0 ||
          busy_v[i] !== 1'b0 || ready_v[i] !== 1'b0 || st_v[i] !== 2'd0) begin
        failures++;
        $display("FAIL reset_vals[%0d] got sync=%b s_out=%h cnt=%0d busy=%b ready=%b st=%0d exp all zero",
                 i, sync_v[i], sout_v[i], cnt_v[i], busy_v[i], ready_v[i], st_v[i]);
      end
      free_at[i]  = 0;
      sync_at[i]  = -1;
      exp_sout[i] = 32'h0;
      exp_cnt[i]  = 0;
    end
    exp_q.delete();
    free_at = '{default: cyc};
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    v_d[0] = 1'b1;
    m_d[0] = 32'd5;
    tick();
    v_d[0] = 1'b0;
    checks++;
    if (sout_v[0] !== 32'd5 || sync_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL basic_emit got s_out=%0d sync=%b exp s_out=5 sync=1", sout_v[0], sync_v[0]);
    end
    tick();
    tick();
    checks++;
    if (ready_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL basic_gap_ready got=%b exp=0", ready_v[0]);
    end
    tick();
    checks++;
    if (ready_v[0] !== 1'b1 || cnt_v[0] !== 16'd1) begin
      failures++;
      $display("FAIL basic_return got ready=%b cnt=%0d exp ready=1 cnt=1", ready_v[0], cnt_v[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] msgs [3];
    int idx;
    int pulses;
    int last_pulse;
    logic prev;
    msgs = '{32'd10, 32'd11, 32'd12};
    do_reset();
    idx = 0; pulses = 0; last_pulse = -10; prev = 1'b0;
    v_d[1] = 1'b1;
    for (int t = 0; t < 20 && pulses < 3; t++) begin
      if (idx < 3) m_d[1] = msgs[idx];
      tick();
      if (hs_last[1]) idx++;
      if (idx >= 3) v_d[1] = 1'b0;
      if (sync_v[1]) begin
        checks++;
        if (sout_v[1] !== msgs[pulses] || prev !== 1'b0) begin
          failures++;
          $display("FAIL b2b_pulse%0d got s_out=%0d prev_sync=%b exp s_out=%0d prev_sync=0",
                   pulses, sout_v[1], prev, msgs[pulses]);
        end
        if (pulses > 0) begin
          checks++;
          if (cyc - last_pulse != 2) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d exp=2", cyc - last_pulse);
          end
        end
        last_pulse = cyc;
        pulses++;
      end
      prev = sync_v[1];
    end
    tick();
    checks++;
    if (pulses != 3 || cnt_v[1] !== 16'd3) begin
      failures++;
      $display("FAIL b2b_count got pulses=%0d cnt=%0d exp pulses=3 cnt=3", pulses, cnt_v[1]);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp2;
    logic [31:0] exp3;
`ifdef MS_SLAVE_FEEDER_SAT_EN
    exp2 = 32'h7fff_ffff;
    exp3 = 32'h8000_0000;
`else
    exp2 = 32'h8000_0000;
    exp3 = 32'h7fff_ffff;
`endif
    do_reset();
    v_d[2] = 1'b1; m_d[2] = 32'h7fff_ffff;
    v_d[3] = 1'b1; m_d[3] = 32'h8000_0000;
    tick();
    v_d[2] = 1'b0; v_d[3] = 1'b0;
    checks++;
    if (sout_v[2] !== exp2 || sout_v[3] !== exp3) begin
      failures++;
      $display("FAIL overflow got pos=%h neg=%h exp pos=%h neg=%h", sout_v[2], sout_v[3], exp2, exp3);
    end
    for (int t = 0; t < 80; t++) begin
      for (int i = 2; i < N; i++) begin
        v_d[i] = 1'($urandom_range(0, 1));
        m_d[i] = pick_msg();
      end
      tick();
    end
    v_d[2] = 1'b0; v_d[3] = 1'b0;
  endtask

  task automatic test_en_gating();
    logic [31:0] held;
    do_reset();
    e_d[0] = 1'b0; v_d[0] = 1'b1; m_d[0] = $urandom;
    repeat (3) tick();
    checks++;
    if (busy_v[0] !== 1'b0 || sout_v[0] !== 32'h0 || hs_last[0] !== 1'b0) begin
      failures++;
      $display("FAIL en_block got busy=%b s_out=%h exp busy=0 s_out=0", busy_v[0], sout_v[0]);
    end
    e_d[0] = 1'b1; held = $urandom; m_d[0] = held;
    tick();
    e_d[0] = 1'b0; m_d[0] = held ^ 32'h5a5a_5a5a;
    repeat (6) tick();
    checks++;
    if (sout_v[0] !== held || busy_v[0] !== 1'b0 || cnt_v[0] !== 16'd1) begin
      failures++;
      $display("FAIL en_gap_complete got s_out=%h busy=%b cnt=%0d exp s_out=%h busy=0 cnt=1",
               sout_v[0], busy_v[0], cnt_v[0], held);
    end
    e_d[0] = 1'b1;
    tick();
    v_d[0] = 1'b0;
    checks++;
    if (sync_v[0] !== 1'b1 || sout_v[0] !== (held ^ 32'h5a5a_5a5a)) begin
      failures++;
      $display("FAIL en_resume got sync=%b s_out=%h exp sync=1 s_out=%h",
               sync_v[0], sout_v[0], held ^ 32'h5a5a_5a5a);
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    v_d[0] = 1'b1; m_d[0] = 32'h0000_0007;
    tick();
    v_d[0] = 1'b0;
    repeat (4) tick();
    v_d[0] = 1'b1; m_d[0] = 32'h1234_5678;
    tick();
    v_d[0] = 1'b0;
    checks++;
    if (sync_v[0] !== 1'b1 || cnt_v[0] !== 16'd1) begin
      failures++;
      $display("FAIL mid_pre got sync=%b cnt=%0d exp sync=1 cnt=1", sync_v[0], cnt_v[0]);
    end
    do_reset();
    for (int t = 0; t < 5; t++) begin
      tick();
      checks++;
      if (sync_v[0] !== 1'b0) begin
        failures++;
        $display("FAIL mid_no_pulse t=%0d got=%b exp=0", t, sync_v[0]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] wrap_exp [5];
    int n;
    logic seen;
    wrap_exp = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
    do_reset();
    n = 0; seen = 1'b0;
    v_d[1] = 1'b1;
    for (int t = 0; t < 40 && n < 5; t++) begin
      m_d[1] = $urandom;
      tick();
      if (seen) begin
        checks++;
        if (cnt_v[1] !== wrap_exp[n]) begin
          failures++;
          $display("FAIL wrap%0d got=%0d exp=%0d", n, cnt_v[1], wrap_exp[n]);
        end
        n++;
      end
      seen = sync_v[1];
    end
    v_d[1] = 1'b0;
    checks++;
    if (n != 5) begin
      failures++;
      $display("FAIL wrap_done got=%0d exp=5", n);
    end
    repeat (3) tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < N; i++) begin
        e_d[i] = ($urandom_range(0, 3) != 0);
        v_d[i] = 1'($urandom_range(0, 1));
        m_d[i] = pick_msg();
      end
      tick();
    end
  endtask

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    for (int i = 0; i < N; i++) begin
      e_d[i] = 1'b1; v_d[i] = 1'b0; m_d[i] = 32'h0; hs_last[i] = 1'b0;
      en_v[i] = 1'b1; valid_v[i] = 1'b0; msg_v[i] = 32'h0;
      free_at[i] = 0; sync_at[i] = -1; exp_sout[i] = 32'h0; exp_cnt[i] = 0;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_back_to_back();
    test_overflow();
    test_en_gating();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ms_slave_feeder.md
Name: ms_slave_feeder

Overview:
- Upstream producer stage for the master/slave test-case modules. It drives the slave data input (32-bit integer) and its one-cycle sync flag.
- Accepts messages from a blocking master port using a valid/ready handshake. Each message gets a signed offset added, is presented to the downstream slave with a single sync pulse, and is followed by a programmable quiet gap.
- Keeps a count of completed transfers.

Parameters:
- OFFSET, 0, signed 32-bit value added to every accepted message.
- GAP_CYCLES, 2, number of idle cycles after each sync pulse before the next message is accepted (0 is legal).
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  accept enable; gates acceptance in IDLE only.
- m_in_msg  input  32  signed message from upstream master.
- m_in_valid  input  1  message valid.
- m_in_ready  output  1  feeder can accept the message this cycle.
- s_out  output  32  signed data to the downstream slave data input.
- s_out_sync  output  1  one-cycle strobe marking s_out as new, to the slave sync input.
- busy  output  1  high whenever the section is not IDLE.
- xfer_cnt  output  CNT_W  number of completed sync pulses, wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, active-high):
  - section = IDLE; s_out = 0; s_out_sync = 0; xfer_cnt = 0; gap counter = 0.
  - m_in_ready = 0 while rst is high.
- Sections: IDLE, EMIT, GAP.
- m_in_ready = (section == IDLE) & en & !rst, combinational. Handshake occurs at a rising edge where m_in_valid & m_in_ready are both high.
- IDLE:
  - On handshake: latch result = m_in_msg + OFFSET into s_out and go to EMIT.
  - Otherwise stay in IDLE; s_out holds its last value.
- EMIT (exactly one cycle):
  - s_out_sync = 1 (registered, high for the whole cycle); xfer_cnt increments at the end of the cycle.
  - Next section is GAP if GAP_CYCLES > 0, else IDLE.
- GAP:
  - s_out_sync = 0; s_out holds.
  - The gap counter loads GAP_CYCLES-1 on entry and decrements each cycle; at 0, return to IDLE.
  - GAP therefore lasts exactly GAP_CYCLES cycles.
- Latency and throughput:
  - Handshake at edge N gives s_out and s_out_sync valid in cycle N+1.
  - One message per (1 + GAP_CYCLES + 1) cycles at best. With GAP_CYCLES=0, back-to-back accepts happen every 2 cycles.
- Arithmetic: 32-bit two's-complement add. Without the optional feature, overflow wraps.
- s_out_sync is never high in two consecutive cycles.
- s_out changes only on the edge that enters EMIT.
- en deasserted during EMIT or GAP: the current transfer completes normally. en only blocks the next acceptance.
- m_in_valid may drop without a handshake; the feeder must not latch in that case.
- Reset mid-EMIT or mid-GAP: immediate abort to reset values, with no further sync pulse.
- xfer_cnt wraps from all-ones to 0 with no flag.

Optional Feature:
- Macro: MS_SLAVE_FEEDER_SAT_EN.
- Defined: the add saturates. Positive overflow yields 0x7FFFFFFF; negative overflow yields 0x80000000.
- Not defined: wraps modulo 2^32.
- All other behaviour is identical in both builds.

Test Plan:
- Reset/basic, OFFSET=0, GAP_CYCLES=2, en=1: assert rst, then send msg=5 → m_in_ready=0 during rst; after handshake s_out=5 and s_out_sync=1 for one cycle; m_in_ready returns high 3 cycles later; xfer_cnt=1.
- Back-to-back, GAP_CYCLES=0, valid held high with msgs 10,11,12 → sync pulses every 2nd cycle, s_out = 10,11,12, xfer_cnt=3, sync never high twice in a row.
- Overflow, OFFSET=1, msg=0x7FFFFFFF → s_out=0x80000000 without the macro; s_out=0x7FFFFFFF with MS_SLAVE_FEEDER_SAT_EN. Also OFFSET=-1, msg=0x80000000 → 0x7FFFFFFF wrap / 0x80000000 saturated.
- en gating: en=0 with valid=1 → no handshake, busy=0, s_out unchanged. Drop en during GAP → the transfer completes and the next accept waits until en=1.
- Reset mid-operation: assert rst in the EMIT cycle → s_out_sync and s_out go to 0 immediately, xfer_cnt=0, no pulse after release until a new handshake.
- Counter wrap, CNT_W=2: 5 transfers → xfer_cnt sequence 1,2,3,0,1.
